// File: rtl/rr_arbiter_nbit.sv
// Round-robin arbiter for 2**N requesters. It drives the select index and the enable
// of a downstream one-hot decoder, and it force-releases a grant after MAX_HOLD cycles.

// One lane per requester: marks requests that sit at or above the priority pointer.
module rr_arb_lane #(
    parameter int N    = 3,
    parameter int LANE = 0
) (
    input  logic         bit_req,
    input  logic [N-1:0] ptr,
    output logic         hi
);
    assign hi = bit_req && (N'(LANE) >= ptr);
endmodule

module rr_arbiter_nbit #(
    parameter int N        = 3,
    parameter int MAX_HOLD = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [2**N-1:0] req,
    input  logic            grant_release,  // current grantee is done
    output logic [N-1:0]    grant_idx,
    output logic            grant_en,
    output logic            timeout
);
    localparam int NREQ = 2**N;
    localparam int CW   = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [CW-1:0] HOLD_LAST = (MAX_HOLD > 0) ? CW'(MAX_HOLD - 1) : '0;
    localparam logic [CW-1:0] CNT_MAX   = '1;

    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

    typedef struct packed {
        state_t         state;
        logic [N-1:0]   idx;
        logic           en;
        logic           tmo;
        logic [N-1:0]   ptr;
        logic [CW-1:0]  cnt;
    } arb_t;

    arb_t cur, nxt;

    logic [NREQ-1:0] hi;
    logic [N-1:0]    winner;
    logic            hold_exp;

    for (genvar i = 0; i < NREQ; i++) begin : g_lane
        rr_arb_lane #(.N(N), .LANE(i)) u_lane (
            .bit_req (req[i]),
            .ptr     (cur.ptr),
            .hi      (hi[i])
        );
    end

    function automatic logic [N-1:0] first_set(input logic [NREQ-1:0] v);
        logic [N-1:0] r;
        r = '0;
        for (int i = NREQ - 1; i >= 0; i--)
            if (v[i]) r = N'(i);
        return r;
    endfunction

    // Requests at or above ptr win first; if there are none, the scan wraps to bit 0.
    assign winner   = (|hi) ? first_set(hi) : first_set(req);
    assign hold_exp = (MAX_HOLD != 0) && (cur.cnt == HOLD_LAST);

    always_comb begin
        nxt     = cur;
        nxt.tmo = 1'b0;
        case (cur.state)
            IDLE: begin
                if (|req) begin
                    nxt.state = GRANT;
                    nxt.idx   = winner;
                    nxt.en    = 1'b1;
                    nxt.cnt   = '0;
                end
            end
            GRANT: begin
                nxt.cnt = (cur.cnt == CNT_MAX) ? cur.cnt : cur.cnt + 1'b1;
                if (grant_release || hold_exp) begin
                    nxt.state = IDLE;
                    nxt.en    = 1'b0;
                    nxt.ptr   = cur.idx + 1'b1;
                    nxt.tmo   = hold_exp && !grant_release;
                end
            end
            default: nxt = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cur <= '0;
        else          cur <= nxt;
    end

    assign grant_idx = cur.idx;
    assign grant_en  = cur.en;
    assign timeout   = cur.tmo;
endmodule

// File: tb/tb_rr_arbiter_nbit.sv
// Directed bench for rr_arbiter_nbit (N=3, MAX_HOLD=16), with hand-derived expectations.
module tb_rr_arbiter_nbit;
    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] req;
    logic       rel;
    logic [2:0] grant_idx;
    logic       grant_en;
    logic       timeout;

    int passed = 0;
    int total  = 0;

    rr_arbiter_nbit #(.N(3), .MAX_HOLD(16)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .req           (req),
        .grant_release (rel),
        .grant_idx     (grant_idx),
        .grant_en      (grant_en),
        .timeout       (timeout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    endtask

    initial begin
        reset_n = 1'b0;
        req     = '0;
        rel     = 1'b0;
        tick();
        tick();
        chk("rst_en",  grant_en,  0);
        chk("rst_idx", grant_idx, 0);
        chk("rst_tmo", timeout,   0);
        reset_n = 1'b1;

        // A single requester, then a release.
        req = 8'b0010_0000;
        tick();
        chk("single_en",  grant_en,  1);
        chk("single_idx", grant_idx, 5);
        rel = 1'b1;
        req = '0;
        tick();
        chk("single_rel_en", grant_en,  0);
        chk("idx_hold_idle", grant_idx, 5);
        rel = 1'b0;

        // ptr=6: the scan skips 6 and 7, wraps to 0, and then moves on to 2.
        req = 8'b0000_0101;
        tick();
        chk("wrap_en",  grant_en,  1);
        chk("wrap_idx", grant_idx, 0);
        rel = 1'b1;
        tick();
        chk("wrap_rel_en", grant_en, 0);
        rel = 1'b0;
        tick();
        chk("skip_en",  grant_en,  1);
        chk("skip_idx", grant_idx, 2);
        rel = 1'b1;
        req = '0;
        tick();
        chk("skip_rel_en",   grant_en,  0);
        chk("skip_idx_hold", grant_idx, 2);

        // A release while IDLE has no effect; ptr=3, so req bit 4 wins.
        tick();
        chk("idle_rel_en",  grant_en, 0);
        chk("idle_rel_tmo", timeout,  0);
        rel = 1'b0;
        req = 8'h10;
        tick();
        chk("drop_en",  grant_en,  1);
        chk("drop_idx", grant_idx, 4);
        req = '0;
        repeat (3) tick();
        chk("drop_held_en",  grant_en,  1);
        chk("drop_held_idx", grant_idx, 4);
        rel = 1'b1;
        tick();
        chk("drop_rel_en", grant_en, 0);
        rel = 1'b0;

        // Reset in the middle of a grant (ptr=5).
        req = 8'hFF;
        tick();
        chk("pre_rst_en",  grant_en,  1);
        chk("pre_rst_idx", grant_idx, 5);
        reset_n = 1'b0;
        #1;
        chk("async_rst_en",  grant_en,  0);
        chk("async_rst_idx", grant_idx, 0);
        tick();
        reset_n = 1'b1;

        // Rotation from ptr=0 with every requester active.
        for (int k = 0; k < 9; k++) begin
            tick();
            chk("rot_en",  grant_en,  1);
            chk("rot_idx", grant_idx, k % 8);
            rel = 1'b1;
            tick();
            chk("rot_gap_en", grant_en, 0);
            rel = 1'b0;
        end
        req = '0;

        // Timeout after exactly 16 cycles of grant (ptr=1, req bit 3).
        req = 8'h08;
        tick();
        chk("to_en0",  grant_en,  1);
        chk("to_idx0", grant_idx, 3);
        for (int c = 1; c < 16; c++) begin
            tick();
            chk("to_hold_en",  grant_en, 1);
            chk("to_hold_tmo", timeout,  0);
        end
        tick();
        chk("to_exit_en",  grant_en, 0);
        chk("to_exit_tmo", timeout,  1);
        tick();
        chk("to_regrant_en",  grant_en,  1);
        chk("to_regrant_idx", grant_idx, 3);
        chk("to_pulse_end",   timeout,   0);

        // Release in the cycle the hold would expire: treated as a release, with no timeout.
        repeat (15) tick();
        chk("coll_pre_en", grant_en, 1);
        rel = 1'b1;
        tick();
        chk("coll_en",  grant_en, 0);
        chk("coll_tmo", timeout,  0);
        rel = 1'b0;
        req = '0;
        tick();
        chk("coll_idle_en",  grant_en, 0);
        chk("coll_idle_tmo", timeout,  0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
